fetch_ctrl: RTL and testbench

- Sequences the program counter and the instruction-memory fetch handshake for the pipelined core.
- Owns the PC register and the pc+4 / redirect next-PC selection.
- Issues at most one outstanding request to instruction memory and holds the returned word in a one-entry output buffer for decode.
- Handles stall backpressure from the hazard unit and redirects from execute (taken branch or jump), discarding any wrong-path response.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl_instr_buf.sv | 43 ++++
 rtl/fetch_ctrl.sv | 95 +++++++++
 tb/tb_fetch_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_instr_buf.sv
// One-entry instruction buffer between fetch and decode.
module instr_buf
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   load,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   free
);

  logic consume;

  assign consume = valid & ~stall;
  assign free    = ~valid | ~stall;

  // Flush only drops the valid flag; the stale word is never presented as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= INSTR_WIDTH'(NOP_INSTR);
      instr_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      instr_pc <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencing and single-outstanding instruction-memory fetch handshake.
//   state   | meaning
//   S_BOOT  | one idle cycle after reset release
//   S_REQ   | request PC while the output buffer is free
//   S_WAIT  | request granted, waiting for read data
//   S_DRAIN | waiting for a wrong-path response to discard
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    RedirectPC,
  output logic                   ImemReq,
  output logic [PC_WIDTH-1:0]    ImemAddr,
  input  logic                   ImemGnt,
  input  logic                   ImemRvalid,
  input  logic [INSTR_WIDTH-1:0] ImemRdata,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic [PC_WIDTH-1:0]    InstrPC
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   req_pc;
  logic [PC_WIDTH-1:0]   redirect_tgt;
  logic                  buf_free;
  logic                  buf_load;
  logic                  buf_flush;
  logic                  req_accept;

  assign redirect_tgt = {RedirectPC[PC_WIDTH-1:2], 2'b00};
  assign ImemReq      = (state == S_REQ) && buf_free;
  assign ImemAddr     = pc;
  assign req_accept   = ImemReq && ImemGnt;
  assign buf_flush    = Redirect && (state != S_BOOT);
  assign buf_load     = (state == S_WAIT) && ImemRvalid && !Redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_BOOT;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (state == S_BOOT) begin
      if (Redirect) pc <= redirect_tgt;
      state <= S_REQ;
    end else if (Redirect) begin
      pc <= redirect_tgt;
      case (state)
        S_REQ:   if (req_accept) state <= S_DRAIN;
        S_WAIT:  state <= ImemRvalid ? S_REQ : S_DRAIN;
        // The pending response arriving with a redirect still retires the drain.
        S_DRAIN: if (ImemRvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (req_accept) begin
            req_pc <= pc;
            pc     <= pc + PC_WIDTH'(4);
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (ImemRvalid) state <= S_REQ;
        S_DRAIN: if (ImemRvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  instr_buf #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_instr_buf (
    .clk        (clk),
    .rst        (rst),
    .stall      (Stall),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_instr (ImemRdata),
    .load_pc    (req_pc),
    .valid      (InstrValid),
    .instr      (Instr),
    .instr_pc   (InstrPC),
    .free       (buf_free)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, stall, grant backpressure, redirects, wrap and reset.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D1  = 32'h0050_0093;
  localparam logic [31:0] D2  = 32'h00A0_0113;
  localparam logic [31:0] D3  = 32'h00F0_0193;
  localparam logic [31:0] D4  = 32'h0140_0213;
  localparam logic [31:0] D5  = 32'h0190_0293;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, gnt, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, valid;
  logic [31:0] addr, instr, instr_pc;
  logic        req_w, valid_w;
  logic [31:0] addr_w, instr_w, instr_pc_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .Stall(stall), .Redirect(redirect), .RedirectPC(redirect_pc),
    .ImemReq(req), .ImemAddr(addr), .ImemGnt(gnt), .ImemRvalid(rvalid), .ImemRdata(rdata),
    .InstrValid(valid), .Instr(instr), .InstrPC(instr_pc)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .Stall(stall), .Redirect(redirect), .RedirectPC(redirect_pc),
    .ImemReq(req_w), .ImemAddr(addr_w), .ImemGnt(gnt), .ImemRvalid(rvalid), .ImemRdata(rdata),
    .InstrValid(valid_w), .Instr(instr_w), .InstrPC(instr_pc_w)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; gnt = 0; rvalid = 0; rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", req); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", valid); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL rst_instr got %h want %h", instr, NOP); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    total++; if (addr_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_pc_w got %h want fffffffc", addr_w); end
    rst = 1'b0;
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL boot_idle_req got %b want 0", req); end
  endtask

  task automatic test_boot();
    gnt = 1'b1;
    cyc();
    total++; if (req !== 1'b1 || addr !== 32'h0) begin bad++; $display("FAIL boot_req got req=%b addr=%h want 1/0", req, addr); end
    total++; if (addr_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got %h want fffffffc", addr_w); end
    cyc();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL wait_req got %b want 0", req); end
    rvalid = 1'b1; rdata = D1;
    cyc();
    rvalid = 1'b0;
    #1;
    total++; if (valid !== 1'b1 || instr !== D1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL boot_load got v=%b i=%h pc=%h want 1/%h/0", valid, instr, instr_pc, D1);
    end
    total++; if (req !== 1'b1 || addr !== 32'h4) begin bad++; $display("FAIL second_req got req=%b addr=%h want 1/4", req, addr); end
    total++; if (addr_w !== 32'h0) begin bad++; $display("FAIL wrap_second got %h want 0", addr_w); end
  endtask

  task automatic test_stall_hold();
    cyc();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL consume got v=%b want 0", valid); end
    rvalid = 1'b1; rdata = D2;
    cyc();
    rvalid = 1'b0; stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) cyc();
      total++; if (req !== 1'b0 || valid !== 1'b1 || instr !== D2 || instr_pc !== 32'h4) begin
        bad++; $display("FAIL stall_hold[%0d] got req=%b v=%b i=%h pc=%h want 0/1/%h/4", i, req, valid, instr, instr_pc, D2);
      end
    end
  endtask

  task automatic test_grant_backpressure();
    stall = 1'b0; gnt = 1'b0;
    #1;
    total++; if (req !== 1'b1 || addr !== 32'h8) begin bad++; $display("FAIL unstall_req got req=%b addr=%h want 1/8", req, addr); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (req !== 1'b1 || addr !== 32'h8 || valid !== 1'b0) begin
        bad++; $display("FAIL gnt_hold[%0d] got req=%b addr=%h v=%b want 1/8/0", i, req, addr, valid);
      end
    end
    gnt = 1'b1;
    cyc();
    rvalid = 1'b1; rdata = D3;
    cyc();
    rvalid = 1'b0;
    #1;
    total++; if (valid !== 1'b1 || instr_pc !== 32'h8 || addr !== 32'hC) begin
      bad++; $display("FAIL after_gnt got v=%b pc=%h addr=%h want 1/8/c", valid, instr_pc, addr);
    end
  endtask

  task automatic test_redirect_in_flight();
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cyc();
    redirect = 1'b0;
    #1;
    total++; if (valid !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL drain got v=%b req=%b want 0/0", valid, req); end
    rvalid = 1'b1; rdata = BAD;
    cyc();
    rvalid = 1'b0;
    #1;
    total++; if (valid !== 1'b0 || instr !== D3) begin bad++; $display("FAIL drop got v=%b i=%h want 0/%h", valid, instr, D3); end
    total++; if (req !== 1'b1 || addr !== 32'h100) begin bad++; $display("FAIL redir_addr got req=%b addr=%h want 1/100", req, addr); end
    cyc();
    rvalid = 1'b1; rdata = D4;
    cyc();
    rvalid = 1'b0;
    #1;
    total++; if (valid !== 1'b1 || instr !== D4 || instr_pc !== 32'h100) begin
      bad++; $display("FAIL redir_load got v=%b i=%h pc=%h want 1/%h/100", valid, instr, instr_pc, D4);
    end
  endtask

  task automatic test_simultaneous();
    cyc();
    rvalid = 1'b1; rdata = BAD; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    rvalid = 1'b0; redirect = 1'b0;
    #1;
    total++; if (valid !== 1'b0 || instr !== D4) begin bad++; $display("FAIL redir_rvalid got v=%b i=%h want 0/%h", valid, instr, D4); end
    total++; if (req !== 1'b1 || addr !== 32'h200) begin bad++; $display("FAIL redir_rvalid_req got req=%b addr=%h want 1/200", req, addr); end
    cyc();
    rvalid = 1'b1; rdata = D5;
    cyc();
    rvalid = 1'b0;
    #1;
    total++; if (valid !== 1'b1 || instr_pc !== 32'h200) begin bad++; $display("FAIL load_200 got v=%b pc=%h want 1/200", valid, instr_pc); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300; gnt = 1'b0;
    cyc();
    stall = 1'b0; redirect = 1'b0; gnt = 1'b1;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL redir_stall got v=%b want 0", valid); end
    total++; if (req !== 1'b1 || addr !== 32'h300) begin bad++; $display("FAIL redir_stall_req got req=%b addr=%h want 1/300", req, addr); end
  endtask

  task automatic test_reset_mid();
    cyc();
    gnt = 1'b0;
    total++; if (req !== 1'b0 || addr !== 32'h304) begin bad++; $display("FAIL pre_rst got req=%b addr=%h want 0/304", req, addr); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (req !== 1'b0 || valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0 || addr !== 32'h0) begin
      bad++; $display("FAIL mid_rst got req=%b v=%b i=%h pc=%h addr=%h want 0/0/%h/0/0", req, valid, instr, instr_pc, addr, NOP);
    end
    total++; if (addr_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL mid_rst_w got %h want fffffffc", addr_w); end
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall_hold();
    test_grant_backpressure();
    test_redirect_in_flight();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
